day_advance_ctrl: RTL and testbench
===================================

# day_advance_ctrl

Sequencer for the calendar day counter on the DE10-Lite. It synchronizes and debounces the speed button, synchronizes the leap-year switch, and divides the 10 MHz board clock into day-advance ticks at normal or fast rate. It owns the 1-based day-of-year count that the month/day conversion and seven-segment stages consume, and it applies the year wrap at 365 or 366. It replaces free-running divider and counter wiring with one controlled FSM.

## Interface
Parameters:
- TICK_DIV, 10_000_000: clock cycles per day in NORMAL mode (1 s at 10 MHz); must be ≥ 2.
- FAST_DIV, 5_000_000: clock cycles per day in FAST mode; must be ≥ 2 and < TICK_DIV.
- DEBOUNCE, 100_000: consecutive stable cycles required before the debounced fast level changes; must be ≥ 1.

Ports:
- ADC_CLK_10  in  1  board clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- key_fast_n  in  1  raw KEY[1], active-low, asynchronous to ADC_CLK_10.
- sw_leap  in  1  raw SW[9], asynchronous; 1 selects a 366-day year.
- day_count  out  9  current day of year, range 1..365, or 1..366 when leap_active=1.
- leap_active  out  1  leap setting latched for the current year.
- day_tick  out  1  one-cycle pulse, high in the cycle day_count changes.
- year_wrap  out  1  one-cycle pulse, coincident with day_tick when day_count returns to 1.
- mode  out  2  00 INIT, 01 NORMAL, 10 FAST; 11 is never driven. Drives LEDR[1:0].

## Operation
- Input conditioning:
  - key_fast_n and sw_leap each pass through a 2-FF synchronizer.
  - fast_req = inverted synchronized key_fast_n.
  - Debouncer: a counter clears whenever fast_req equals fast_db. It increments while they differ. When it reaches DEBOUNCE-1, fast_db takes fast_req and the counter clears.
- FSM:
  - INIT: holds for exactly 2 cycles after reset deasserts. On the 3rd edge: leap_active <= synchronized sw_leap, prescaler <= 0, go to NORMAL.
  - NORMAL: fast_db=1 moves to FAST.
  - FAST: fast_db=0 moves to NORMAL.
  - Every NORMAL↔FAST transition clears the prescaler in that same edge. No tick is issued on the transition edge.
- Prescaler: counts 0..DIV-1, where DIV is TICK_DIV in NORMAL and FAST_DIV in FAST. At DIV-1 it wraps to 0 and advances the day.
- Day advance:
  - If day_count < last, day_count+1. last = 366 if leap_active else 365.
  - If day_count == last, day_count <= 1, year_wrap=1, and leap_active reloads from synchronized sw_leap in that same edge.
  - day_tick=1 on every advance.
- Leap changes mid-year are ignored until the next wrap or reset.
- Width rule: day_count is never 0 and never exceeds last. All counters are sized with $clog2 of their parameter.

## Timing
- Reset values (edge with reset=1): day_count=1, leap_active=0, day_tick=0, year_wrap=0, mode=00, prescaler=0, fast_db=0, debounce counter=0, synchronizers=0.
- Reset overrides every other event. Reset mid-operation returns all outputs to their reset values on that edge, including any pulse due that cycle.
- First day_tick: TICK_DIV cycles after the edge that enters NORMAL, or FAST_DIV cycles if in FAST.
- Button latency:
  - Press: 2 sync cycles + DEBOUNCE cycles to fast_db, then +1 cycle to the mode change.
  - Release: same latency.
  - Glitches shorter than DEBOUNCE cycles have no effect.
- Tick coincident with a debounced mode change: the mode change wins, the prescaler clears, and no advance occurs.
- day_tick and year_wrap are registered outputs, high exactly 1 cycle each.

## Test plan
Bench parameters: TICK_DIV=4, FAST_DIV=2, DEBOUNCE=3.
1. Reset for 2 cycles, sw_leap=0, key_fast_n=1, then release:
   - mode=00 and day_count=1 for 2 cycles after release.
   - mode=01 on the 3rd edge.
   - day_count=2 with day_tick=1 exactly 4 cycles later.
2. Non-leap wrap: run 364 ticks to day_count=365. The next tick gives day_count=1 with year_wrap=1 and day_tick=1 for one cycle. day_count never reads 366.
3. Leap year:
   - sw_leap=1 through reset: leap_active=1, day_count reaches 366, then wraps to 1.
   - sw_leap=0 at day 100: leap_active stays 1 until that wrap, then reads 0.
4. Fast mode:
   - key_fast_n low for 2 cycles: no mode change.
   - Held low: mode=10 exactly 6 cycles after the falling input, then ticks every 2 cycles.
   - Release: mode=01 after 6 cycles, ticks every 4 cycles.
5. Reset mid-run at day_count=200 in FAST, asserted on a tick cycle: same edge gives day_count=1, day_tick=0, year_wrap=0, mode=00.

Source files
------------

// File: rtl/day_advance_ctrl.sv
// Day-of-year sequencer: conditions the speed button and leap switch, divides the
// board clock into day ticks at normal or fast rate, and wraps the year at 365/366.
`timescale 1ns/1ps
module day_advance_ctrl #(
  parameter int TICK_DIV = 10_000_000,
  parameter int FAST_DIV = 5_000_000,
  parameter int DEBOUNCE = 100_000
) (
  input  logic       ADC_CLK_10,
  input  logic       reset,
  input  logic       key_fast_n,
  input  logic       sw_leap,
  output logic [8:0] day_count,
  output logic       leap_active,
  output logic       day_tick,
  output logic       year_wrap,
  output logic [1:0] mode
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [PS_W-1:0] TICK_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0] FAST_LAST  = PS_W'(FAST_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE - 1);
  localparam logic [1:0]      INIT_HOLD  = 2'd2;
  localparam logic [8:0]      DAYS_PLAIN = 9'd365;
  localparam logic [8:0]      DAYS_LEAP  = 9'd366;

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_NORMAL = 2'b01,
    ST_FAST   = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0]      key_sync;
  logic [1:0]      leap_sync;
  logic            fast_req;
  logic            fast_db;
  logic [DB_W-1:0] db_cnt;
  logic [1:0]      init_cnt;
  logic [PS_W-1:0] prescaler;
  logic [PS_W-1:0] div_last;
  logic [8:0]      last_day;
  logic            ps_done;
  logic            mode_change;

  // Both raw inputs are asynchronous to the board clock.
  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      key_sync  <= 2'b00;
      leap_sync <= 2'b00;
    end else begin
      key_sync  <= {key_sync[0], key_fast_n};
      leap_sync <= {leap_sync[0], sw_leap};
    end
  end

  assign fast_req = ~key_sync[1];

  // fast_db only follows fast_req after DEBOUNCE consecutive cycles of disagreement.
  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      db_cnt  <= '0;
      fast_db <= 1'b0;
    end else if (fast_req == fast_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt  <= '0;
      fast_db <= fast_req;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      init_cnt <= 2'd0;
    end else if ((state_q == ST_INIT) && (init_cnt != INIT_HOLD)) begin
      init_cnt <= init_cnt + 2'd1;
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (init_cnt == INIT_HOLD) state_d = ST_NORMAL;
      ST_NORMAL: if (fast_db)               state_d = ST_FAST;
      ST_FAST:   if (!fast_db)              state_d = ST_NORMAL;
      default:                              state_d = ST_INIT;
    endcase
  end

  always_comb begin
    mode = 2'b00;
    case (state_q)
      ST_NORMAL: mode = 2'b01;
      ST_FAST:   mode = 2'b10;
      default:   mode = 2'b00;
    endcase
  end

  assign div_last    = (state_q == ST_FAST) ? FAST_LAST : TICK_LAST;
  assign ps_done     = (prescaler == div_last);
  assign last_day    = leap_active ? DAYS_LEAP : DAYS_PLAIN;
  assign mode_change = (state_d != state_q);

  // A rate change restarts the day period and swallows a tick due on the same edge.
  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      prescaler   <= '0;
      day_count   <= 9'd1;
      leap_active <= 1'b0;
      day_tick    <= 1'b0;
      year_wrap   <= 1'b0;
    end else begin
      day_tick  <= 1'b0;
      year_wrap <= 1'b0;
      if (state_q == ST_INIT) begin
        prescaler <= '0;
        if (mode_change) leap_active <= leap_sync[1];
      end else if (mode_change) begin
        prescaler <= '0;
      end else if (ps_done) begin
        prescaler <= '0;
        day_tick  <= 1'b1;
        if (day_count >= last_day) begin
          day_count   <= 9'd1;
          year_wrap   <= 1'b1;
          leap_active <= leap_sync[1];
        end else begin
          day_count <= day_count + 9'd1;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  a_mode_legal: assert property (@(posedge ADC_CLK_10) disable iff (reset) mode != 2'b11);
  a_day_range:  assert property (@(posedge ADC_CLK_10) disable iff (reset)
                                 (day_count != 9'd0) && (day_count <= last_day));
  a_wrap_tick:  assert property (@(posedge ADC_CLK_10) disable iff (reset) year_wrap |-> day_tick);

endmodule

// File: tb/tb_day_advance_ctrl.sv
// Directed bench for day_advance_ctrl with small dividers (4/2) and a 3-cycle debounce.
`timescale 1ns/1ps
module tb_day_advance_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_fast_n;
  logic       sw_leap;
  logic [8:0] day_count;
  logic       leap_active;
  logic       day_tick;
  logic       year_wrap;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;
  int exp_day;
  int cyc;

  day_advance_ctrl #(
    .TICK_DIV(4),
    .FAST_DIV(2),
    .DEBOUNCE(3)
  ) dut (
    .ADC_CLK_10 (clk),
    .reset      (reset),
    .key_fast_n (key_fast_n),
    .sw_leap    (sw_leap),
    .day_count  (day_count),
    .leap_active(leap_active),
    .day_tick   (day_tick),
    .year_wrap  (year_wrap),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic key_n, input logic leap);
    reset      = rst;
    key_fast_n = key_n;
    sw_leap    = leap;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance n edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitTick(output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while ((day_tick !== 1'b1) && (cycles < 64));
    checkOutput("tick_seen", int'(day_tick), 1);
  endtask

  task automatic resetAndEnter(input logic leap);
    applyStimulus(1'b1, 1'b1, leap);
    step(2);
    applyStimulus(1'b0, 1'b1, leap);
    step(3);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, INIT hold and first tick
    applyStimulus(1'b1, 1'b1, 1'b0);
    step(2);
    checkOutput("rst_day", day_count, 1);
    checkOutput("rst_mode", mode, 0);
    checkOutput("rst_tick", day_tick, 0);
    checkOutput("rst_wrap", year_wrap, 0);
    checkOutput("rst_leap", leap_active, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("init_c1_mode", mode, 0);
    step(1);
    checkOutput("init_c2_mode", mode, 0);
    checkOutput("init_c2_day", day_count, 1);
    step(1);
    checkOutput("enter_normal", mode, 1);
    checkOutput("enter_leap", leap_active, 0);
    step(3);
    checkOutput("pre_tick_day", day_count, 1);
    checkOutput("pre_tick", day_tick, 0);
    step(1);
    checkOutput("first_tick_day", day_count, 2);
    checkOutput("first_tick", day_tick, 1);
    step(1);
    checkOutput("first_tick_drop", day_tick, 0);

    // Non-leap year wrap
    exp_day = 2;
    for (int i = 0; i < 363; i++) begin
      waitTick(cyc);
      exp_day++;
      checkOutput("nl_day", day_count, exp_day);
      if (i > 0) checkOutput("nl_period", cyc, 4);
    end
    checkOutput("nl_last_wrap", year_wrap, 0);
    waitTick(cyc);
    checkOutput("nl_wrap_day", day_count, 1);
    checkOutput("nl_wrap_pulse", year_wrap, 1);
    checkOutput("nl_wrap_leap", leap_active, 0);
    step(1);
    checkOutput("nl_wrap_drop", year_wrap, 0);
    checkOutput("nl_tick_drop", day_tick, 0);

    // Leap year, switch dropped mid-year takes effect only at the wrap
    resetAndEnter(1'b1);
    checkOutput("lp_mode", mode, 1);
    checkOutput("lp_active", leap_active, 1);
    exp_day = 1;
    for (int i = 0; i < 99; i++) begin
      waitTick(cyc);
      exp_day++;
      checkOutput("lp_day", day_count, exp_day);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 266; i++) begin
      waitTick(cyc);
      exp_day++;
      checkOutput("lp_day", day_count, exp_day);
    end
    checkOutput("lp_day366_leap", leap_active, 1);
    checkOutput("lp_day366_wrap", year_wrap, 0);
    waitTick(cyc);
    checkOutput("lp_wrap_day", day_count, 1);
    checkOutput("lp_wrap_pulse", year_wrap, 1);
    checkOutput("lp_wrap_leap", leap_active, 0);

    // Fast mode: glitch, press (coincident with a normal tick), release
    resetAndEnter(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(8);
    checkOutput("glitch_mode", mode, 1);
    checkOutput("glitch_day", day_count, 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(5);
    checkOutput("press_c5_mode", mode, 1);
    checkOutput("press_c5_day", day_count, 4);
    step(1);
    checkOutput("press_mode", mode, 2);
    checkOutput("coincide_day", day_count, 4);
    checkOutput("coincide_tick", day_tick, 0);
    step(1);
    checkOutput("fast_c1_tick", day_tick, 0);
    step(1);
    checkOutput("fast_c2_tick", day_tick, 1);
    checkOutput("fast_c2_day", day_count, 5);
    step(2);
    checkOutput("fast_c4_tick", day_tick, 1);
    checkOutput("fast_c4_day", day_count, 6);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(5);
    checkOutput("release_c5_mode", mode, 2);
    step(1);
    checkOutput("release_mode", mode, 1);
    checkOutput("release_day", day_count, 8);
    checkOutput("release_tick", day_tick, 0);
    step(3);
    checkOutput("norm_c3_tick", day_tick, 0);
    step(1);
    checkOutput("norm_c4_tick", day_tick, 1);
    checkOutput("norm_c4_day", day_count, 9);
    step(4);
    checkOutput("norm_c8_day", day_count, 10);

    // Reset on a tick edge at day 200 in FAST
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(6);
    checkOutput("fast2_mode", mode, 2);
    checkOutput("fast2_day", day_count, 11);
    exp_day = 11;
    for (int i = 0; i < 189; i++) begin
      waitTick(cyc);
      exp_day++;
      checkOutput("fast2_day", day_count, exp_day);
      checkOutput("fast2_period", cyc, 2);
    end
    step(1);
    checkOutput("pre_rst_tick", day_tick, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("midrst_day", day_count, 1);
    checkOutput("midrst_tick", day_tick, 0);
    checkOutput("midrst_wrap", year_wrap, 0);
    checkOutput("midrst_mode", mode, 0);
    checkOutput("midrst_leap", leap_active, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
